// File: rtl/cmd_input.sv
// rtl/cmd_input.sv - button debounce, operand entry and PUSH/EXEC command issue
// Front-end command stage feeding the stack calculator over a valid/ready handshake.
module cmd_input #(
  parameter int DB_BITS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  btn,
  input  logic [7:0]  sw,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [3:0]  cmd_op,
  output logic [31:0] cmd_arg,
  output logic [31:0] entry,
  output logic [2:0]  entry_len,
  output logic        reject
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [DB_BITS-1:0] CNT_MAX = '1;

  state_t             state;
  logic [3:1]         db_lvl;
  logic [3:1]         press;
  logic [DB_BITS-1:0] db_cnt [3:1];

  // btn[0] selects the display half and is consumed elsewhere
  logic unused_btn0;
  assign unused_btn0 = btn[0];

  // A level is accepted only after it differs from the debounced level for 2^DB_BITS cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_lvl <= '0;
      press  <= '0;
      for (int i = 1; i <= 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 1; i <= 3; i++) begin
        press[i] <= 1'b0;
        if (btn[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          db_lvl[i] <= btn[i];
          db_cnt[i] <= '0;
          press[i]  <= btn[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_op    <= '0;
      cmd_arg   <= '0;
      entry     <= '0;
      entry_len <= '0;
      reject    <= 1'b0;
    end else begin
      reject <= 1'b0;
      case (state)
        IDLE: begin
          // BYTE wins over PUSH wins over EXEC; losers of a tie are rejected
          if (press[3]) begin
            entry  <= {entry[23:0], sw};
            reject <= |press[2:1];
            if (entry_len != 3'd4) entry_len <= entry_len + 3'd1;
          end else if (press[2]) begin
            cmd_valid <= 1'b1;
            cmd_op    <= 4'd0;
            cmd_arg   <= entry;
            entry     <= '0;
            entry_len <= '0;
            reject    <= press[1];
            state     <= ISSUE;
          end else if (press[1]) begin
            if (sw[3:0] == 4'd0) begin
              reject <= 1'b1;
            end else begin
              cmd_valid <= 1'b1;
              cmd_op    <= sw[3:0];
              cmd_arg   <= '0;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          reject <= |press;
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_arg   <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_input.sv
// tb/tb_cmd_input.sv - scoreboard bench for cmd_input with DB_BITS=4
// Expected commands are queued at stimulus time and popped on each handshake.
module tb_cmd_input;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  btn;
  logic [7:0]  sw;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic [31:0] entry;
  logic [2:0]  entry_len;
  logic        reject;

  int checks = 0;
  int errors = 0;
  int rej_cnt = 0;
  int hs_cnt = 0;
  logic [35:0] sb[$];

  cmd_input #(.DB_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .sw(sw),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_arg(cmd_arg), .entry(entry), .entry_len(entry_len), .reject(reject)
  );

  always #5 clk = ~clk;

  // Handshake monitor: inputs change at posedge+1, so negedge sees the values the next edge uses
  always @(negedge clk) begin
    if (rst_n) begin
      if (reject) rej_cnt++;
      if (cmd_valid && cmd_ready) begin
        hs_cnt++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd got op=%0h arg=%h req none", cmd_op, cmd_arg);
        end else begin
          logic [35:0] exp_cmd;
          exp_cmd = sb.pop_front();
          if ({cmd_op, cmd_arg} !== exp_cmd) begin
            errors++;
            $display("FAIL cmd_payload got %h req %h", {cmd_op, cmd_arg}, exp_cmd);
          end
        end
      end
    end
  end

  task automatic hold_btn(input logic [3:0] mask, input int n);
    btn = mask;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; btn = '0; sw = '0; cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_valid, cmd_op, cmd_arg} !== 37'd0) begin
      errors++; $display("FAIL reset_cmd got %h req 0", {cmd_valid, cmd_op, cmd_arg});
    end
    checks++;
    if ({entry, entry_len, reject} !== 36'd0) begin
      errors++; $display("FAIL reset_entry got %h req 0", {entry, entry_len, reject});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_debounce;
    hold_btn(4'h8, 10);
    hold_btn(4'h0, 20);
    checks++;
    if ({entry, entry_len} !== 35'd0) begin
      errors++; $display("FAIL glitch got entry=%h len=%0d req 0", entry, entry_len);
    end
    sw = 8'hA5;
    hold_btn(4'h8, 20);
    hold_btn(4'h0, 20);
    checks++;
    if (entry !== 32'h000000A5 || entry_len !== 3'd1) begin
      errors++; $display("FAIL single_byte got entry=%h len=%0d req 000000a5 1", entry, entry_len);
    end
  endtask

  task automatic test_bytes;
    logic [7:0] bytes [5];
    bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A};
    for (int i = 0; i < 5; i++) begin
      sw = bytes[i];
      hold_btn(4'h8, 20);
      hold_btn(4'h0, 20);
    end
    checks++;
    if (entry !== 32'h3456789A || entry_len !== 3'd4) begin
      errors++; $display("FAIL byte_shift got entry=%h len=%0d req 3456789a 4", entry, entry_len);
    end
  endtask

  task automatic test_push_hold;
    int h0;
    cmd_ready = 1'b0;
    sb.push_back({4'h0, 32'h3456789A});
    btn = 4'h4;
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL push_early got %b req 0", cmd_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({cmd_valid, cmd_op, cmd_arg} !== {1'b1, 4'h0, 32'h3456789A}) begin
      errors++; $display("FAIL push_issue got %h req 103456789a", {cmd_valid, cmd_op, cmd_arg});
    end
    checks++;
    if ({entry, entry_len} !== 35'd0) begin
      errors++; $display("FAIL push_clear got entry=%h len=%0d req 0", entry, entry_len);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if ({cmd_valid, cmd_op, cmd_arg} !== {1'b1, 4'h0, 32'h3456789A}) begin
      errors++; $display("FAIL push_hold got %h req 103456789a", {cmd_valid, cmd_op, cmd_arg});
    end
    h0 = hs_cnt;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_valid !== 1'b0 || hs_cnt !== h0 + 1) begin
      errors++; $display("FAIL push_done got valid=%b hs=%0d req 0 %0d", cmd_valid, hs_cnt, h0 + 1);
    end
    hold_btn(4'h0, 20);
  endtask

  task automatic test_exec;
    int r0, h0;
    cmd_ready = 1'b1;
    sw = 8'h03;
    sb.push_back({4'h3, 32'h0});
    btn = 4'h2;
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++; $display("FAIL exec_early got %b req 0", cmd_valid);
    end
    @(posedge clk); #1;
    checks++;
    if ({cmd_valid, cmd_op, cmd_arg} !== {1'b1, 4'h3, 32'h0}) begin
      errors++; $display("FAIL exec_issue got %h req 1300000000", {cmd_valid, cmd_op, cmd_arg});
    end
    hold_btn(4'h2, 5);
    hold_btn(4'h0, 20);
    r0 = rej_cnt; h0 = hs_cnt;
    sw = 8'h00;
    hold_btn(4'h2, 20);
    hold_btn(4'h0, 20);
    checks++;
    if (rej_cnt !== r0 + 1 || hs_cnt !== h0) begin
      errors++; $display("FAIL exec_zero got rej=%0d hs=%0d req %0d %0d", rej_cnt, hs_cnt, r0 + 1, h0);
    end
  endtask

  task automatic test_issue_reject;
    int r0;
    cmd_ready = 1'b1;
    sw = 8'h77;
    hold_btn(4'h8, 20);
    hold_btn(4'h0, 20);
    cmd_ready = 1'b0;
    sw = 8'h05;
    sb.push_back({4'h5, 32'h0});
    hold_btn(4'h2, 20);
    hold_btn(4'h0, 20);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_op !== 4'h5) begin
      errors++; $display("FAIL issue_wait got valid=%b op=%0h req 1 5", cmd_valid, cmd_op);
    end
    r0 = rej_cnt;
    sw = 8'hEE;
    hold_btn(4'h8, 20);
    hold_btn(4'h0, 20);
    checks++;
    if (rej_cnt !== r0 + 1) begin
      errors++; $display("FAIL issue_reject got %0d req %0d", rej_cnt, r0 + 1);
    end
    checks++;
    if (entry !== 32'h77 || entry_len !== 3'd1 || cmd_valid !== 1'b1) begin
      errors++; $display("FAIL issue_entry got entry=%h len=%0d valid=%b req 00000077 1 1", entry, entry_len, cmd_valid);
    end
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_valid !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL issue_done got valid=%b pending=%0d req 0 0", cmd_valid, sb.size());
    end
  endtask

  task automatic test_simultaneous;
    int r0, h0;
    cmd_ready = 1'b1;
    r0 = rej_cnt; h0 = hs_cnt;
    sw = 8'hC3;
    hold_btn(4'hC, 20);
    hold_btn(4'h0, 20);
    checks++;
    if (entry !== 32'h77C3 || entry_len !== 3'd2) begin
      errors++; $display("FAIL simul_entry got entry=%h len=%0d req 000077c3 2", entry, entry_len);
    end
    checks++;
    if (rej_cnt !== r0 + 1 || hs_cnt !== h0) begin
      errors++; $display("FAIL simul_reject got rej=%0d hs=%0d req %0d %0d", rej_cnt, hs_cnt, r0 + 1, h0);
    end
  endtask

  task automatic test_reset_mid;
    cmd_ready = 1'b0;
    sb.push_back({4'h0, 32'h77C3});
    hold_btn(4'h4, 20);
    checks++;
    if (cmd_valid !== 1'b1 || cmd_arg !== 32'h77C3) begin
      errors++; $display("FAIL mid_issue got valid=%b arg=%h req 1 000077c3", cmd_valid, cmd_arg);
    end
    #2;
    rst_n = 1'b0;
    btn = 4'h0;
    #1;
    checks++;
    if (cmd_valid !== 1'b0 || entry !== 32'h0) begin
      errors++; $display("FAIL async_reset got valid=%b entry=%h req 0 0", cmd_valid, entry);
    end
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset;
    test_debounce;
    test_bytes;
    test_push_hold;
    test_exec;
    test_issue_reject;
    test_simultaneous;
    test_reset_mid;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d req 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
